// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB first on w and
// keeps a saturating count of the overlapping 110/101 triples seen on the line.
module pattern_tx #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4,
  parameter int MATCH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   data,
  input  logic [LEN_W-1:0]   len,
  input  logic               clr_cnt,
  output logic               ready,
  output logic               w,
  output logic               w_valid,
  output logic               done,
  output logic [MATCH_W-1:0] match_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [LEN_W-1:0]   WIDTH_L   = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0]   LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = {MATCH_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);

  function automatic logic is_match(input logic [2:0] triple);
    is_match = (triple == 3'b110) || (triple == 3'b101);
  endfunction

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               w_q, w_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [1:0]         hist_q, hist_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [LEN_W-1:0]   eff_len_s;
  logic               accept_s;

  // Clamp the requested length to the frame width and qualify the handshake.
  always_comb begin
    eff_len_s = len;
    if (len > WIDTH_L) begin
      eff_len_s = WIDTH_L;
    end else begin
      eff_len_s = len;
    end
    accept_s = (state_q == ST_IDLE) && ready_q && load && (eff_len_s != LEN_ZERO);
  end

  // Frame sequencing; outputs are registered decodes of the current state,
  // so the line lags the state by one clock.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          shreg_d = data << (WIDTH_L - eff_len_s);
          cnt_d   = eff_len_s;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - LEN_ONE;
        if (cnt_q == LEN_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = {WIDTH{1'b0}};
        cnt_d   = LEN_ZERO;
      end
    endcase

    w_d     = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    valid_d = (state_q == ST_SHIFT);
    done_d  = (state_q == ST_DONE);
    ready_d = (state_q == ST_IDLE) && !accept_s;
  end

  // Line history and match counter; idle zeros are real line bits too.
  always_comb begin
    hist_d  = {hist_q[0], w_q};
    match_d = match_q;
    if (clr_cnt) begin
      match_d = {MATCH_W{1'b0}};
    end else if (is_match({hist_q, w_q}) && (match_q != MATCH_MAX)) begin
      match_d = match_q + MATCH_ONE;
    end else begin
      match_d = match_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= LEN_ZERO;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      hist_q  <= 2'b00;
      match_q <= {MATCH_W{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      hist_q  <= hist_d;
      match_q <= match_d;
    end
  end

  assign ready     = ready_q;
  assign w         = w_q;
  assign w_valid   = valid_q;
  assign done      = done_q;
  assign match_cnt = match_q;

endmodule
